// File: rtl/i2s_sample_tx.sv
// Stereo I2S transmitter. It latches one mixer sample per frame, sends it on both channels and
// pulses a frame strobe. Optional `VOLUME_SHIFT_EN adds an arithmetic attenuation on volume_shift.
module i2s_sample_tx #(
  parameter int unsigned CLK_DIV  = 16,
  parameter int unsigned SAMPLE_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                mute,
`ifdef VOLUME_SHIFT_EN
  input  logic [2:0]          volume_shift,
`endif
  output logic                sample_strobe,
  output logic                bclk,
  output logic                lrclk,
  output logic                sdata
);

  localparam int unsigned DIV_W  = 8;
  localparam int unsigned SLOT_W = $clog2(2 * SAMPLE_W);
  localparam int unsigned BIT_W  = $clog2(SAMPLE_W);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [SLOT_W-1:0] SLOT_HALF = SLOT_W'(SAMPLE_W);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(2 * SAMPLE_W - 1);
  localparam logic [SLOT_W-1:0] SLOT_WRAP = SLOT_W'(2 * SAMPLE_W);

  logic [DIV_W-1:0]    div_q, div_d;
  logic                bclk_q, bclk_d;
  logic                lrclk_q, lrclk_d;
  logic                sdata_q, sdata_d;
  logic                strobe_q, strobe_d;
  logic [SAMPLE_W-1:0] sample_q, sample_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic                rlsb_q, rlsb_d;

  logic                fall;
  logic [SLOT_W-1:0]   slot_n;
  logic [BIT_W-1:0]    bit_idx;
  logic [SAMPLE_W-1:0] latch_val;

`ifdef VOLUME_SHIFT_EN
  logic signed [SAMPLE_W-1:0] shifted;
  assign shifted   = $signed(sample_in) >>> volume_shift;
  assign latch_val = mute ? '0 : shifted;
`else
  assign latch_val = mute ? '0 : sample_in;
`endif

  always_comb begin
    // NOTE: every variable gets a default first so no path through this block can infer a latch.
    div_d    = div_q + DIV_W'(1);
    bclk_d   = bclk_q;
    lrclk_d  = lrclk_q;
    sdata_d  = sdata_q;
    strobe_d = 1'b0;
    sample_d = sample_q;
    slot_d   = slot_q;
    rlsb_d   = rlsb_q;
    fall     = 1'b0;

    if (div_q == DIV_LAST) begin
      div_d  = '0;
      bclk_d = ~bclk_q;
      fall   = bclk_q;
    end

    // Slot k carries word bit (16-k) or (32-k); the subtraction from SLOT_WRAP wraps modulo 32.
    slot_n  = slot_q + SLOT_W'(1);
    bit_idx = BIT_W'((slot_n <= SLOT_HALF) ? (SLOT_HALF - slot_n) : (SLOT_WRAP - slot_n));

    if (fall) begin
      slot_d  = slot_n;
      lrclk_d = (slot_n >= SLOT_HALF);
      if (slot_n == '0) begin
        sdata_d  = rlsb_q;
        sample_d = latch_val;
        strobe_d = 1'b1;
      end else begin
        sdata_d = sample_q[bit_idx];
      end
      // The right LSB leaves in the next frame's slot 0, after sample_q has already been reloaded.
      if (slot_n == SLOT_LAST) begin
        rlsb_d = sample_q[0];
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (reset) begin
      div_q    <= '0;
      bclk_q   <= 1'b0;
      lrclk_q  <= 1'b0;
      sdata_q  <= 1'b0;
      strobe_q <= 1'b0;
      sample_q <= '0;
      slot_q   <= SLOT_LAST;
      rlsb_q   <= 1'b0;
    end else begin
      div_q    <= div_d;
      bclk_q   <= bclk_d;
      lrclk_q  <= lrclk_d;
      sdata_q  <= sdata_d;
      strobe_q <= strobe_d;
      sample_q <= sample_d;
      slot_q   <= slot_d;
      rlsb_q   <= rlsb_d;
    end
  end

  assign sample_strobe = strobe_q;
  assign bclk          = bclk_q;
  assign lrclk         = lrclk_q;
  assign sdata         = sdata_q;

endmodule

// File: tb/tb_i2s_sample_tx.sv
// Bench for i2s_sample_tx. An I2S receiver model decodes words on bclk rising edges and compares
// each word against the sample captured at its strobe; vector tables and sequences cover the corner cases.
module tb_i2s_sample_tx;

  localparam int CLK_DIV    = 2;
  localparam int FRAME_CLKS = 2 * CLK_DIV * 32;

  logic        clk       = 1'b0;
  logic        reset     = 1'b1;
  logic [15:0] sample_in = 16'h0000;
  logic        mute      = 1'b0;
`ifdef VOLUME_SHIFT_EN
  logic [2:0]  volume_shift = 3'd0;
`endif
  logic        sample_strobe, bclk, lrclk, sdata;

  i2s_sample_tx #(.CLK_DIV(CLK_DIV), .SAMPLE_W(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_in    (sample_in),
    .mute         (mute),
`ifdef VOLUME_SHIFT_EN
    .volume_shift (volume_shift),
`endif
    .sample_strobe(sample_strobe),
    .bclk         (bclk),
    .lrclk        (lrclk),
    .sdata        (sdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs and reset as the DUT saw them on the last rising edge.
  logic [15:0] in_s  = 16'h0000;
  logic        in_m  = 1'b0;
  logic        rst_s = 1'b1;
  int          cyc   = 0;
`ifdef VOLUME_SHIFT_EN
  logic [2:0]  in_v  = 3'd0;
`endif
  always @(posedge clk) begin
    in_s  <= sample_in;
    in_m  <= mute;
    rst_s <= reset;
    cyc   <= cyc + 1;
`ifdef VOLUME_SHIFT_EN
    in_v  <= volume_shift;
`endif
  end

  function automatic logic [15:0] ref_word(input logic [15:0] s, input logic m, input int sh);
    int v;
    if (m) return 16'h0000;
    v = $signed(s);
    return 16'(v >>> sh);
  endfunction

  // I2S receiver model: a word ends on the bclk rise where lrclk differs from the previous rise.
  logic        prev_bclk = 1'b0, prev_ws = 1'b0, have_strobe = 1'b0;
  logic [15:0] shreg = 16'h0, exp_cur = 16'h0, exp_prev = 16'h0;
  logic [15:0] last_left = 16'h0, last_right = 16'h0;
  int          n_left = 0, n_right = 0, last_strobe_cyc = 0;

  always @(negedge clk) begin
    if (rst_s === 1'b1) begin
      prev_bclk   = 1'b0;
      prev_ws     = 1'b0;
      shreg       = 16'h0;
      have_strobe = 1'b0;
    end else begin
      if (sample_strobe === 1'b1) begin
        if (have_strobe) check("frame_len", cyc - last_strobe_cyc, FRAME_CLKS);
        have_strobe     = 1'b1;
        last_strobe_cyc = cyc;
        exp_prev        = exp_cur;
`ifdef VOLUME_SHIFT_EN
        exp_cur = ref_word(in_s, in_m, int'(in_v));
`else
        exp_cur = ref_word(in_s, in_m, 0);
`endif
      end
      if (bclk === 1'b1 && prev_bclk === 1'b0) begin
        shreg = {shreg[14:0], sdata};
        if (lrclk !== prev_ws) begin
          if (prev_ws == 1'b0) begin
            last_left = shreg;
            n_left++;
            check("left_word", shreg, exp_cur);
          end else begin
            last_right = shreg;
            n_right++;
            check("right_word", shreg, exp_prev);
          end
        end
        prev_ws = lrclk;
      end
      prev_bclk = bclk;
    end
  end

  task automatic wait_words(input string what, input int target, input bit right);
    for (int i = 0; i < 4 * FRAME_CLKS; i++) begin
      if ((right ? n_right : n_left) >= target) return;
      @(negedge clk); #1;
    end
    check({what, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_strobe(input string what);
    for (int i = 0; i < 2 * FRAME_CLKS; i++) begin
      @(negedge clk); #1;
      if (sample_strobe === 1'b1) return;
    end
    check({what, "_timeout"}, 32'd0, 32'd1);
  endtask

  typedef struct {
    logic [15:0] sample;
    logic        mute;
    logic        bclk;
    logic        lrclk;
    logic        sdata;
    logic        strobe;
  } vec_t;

  vec_t tbl[12];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nl, nr, k;

    // Per-clock expectations after reset release, CLK_DIV=2. The latch happens on edge 4 only.
    tbl[0]  = '{16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{16'h1234, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{16'h1234, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{16'hA5C3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    repeat (4) @(negedge clk);
    #1;
    check("rst_bclk",   bclk,          1'b0);
    check("rst_lrclk",  lrclk,         1'b0);
    check("rst_sdata",  sdata,         1'b0);
    check("rst_strobe", sample_strobe, 1'b0);

    nl = n_left;
    nr = n_right;
    reset = 1'b0;
    foreach (tbl[i]) begin
      sample_in = tbl[i].sample;
      mute      = tbl[i].mute;
      @(negedge clk); #1;
      check($sformatf("vec%0d_bclk", i + 1),   bclk,          tbl[i].bclk);
      check($sformatf("vec%0d_lrclk", i + 1),  lrclk,         tbl[i].lrclk);
      check($sformatf("vec%0d_sdata", i + 1),  sdata,         tbl[i].sdata);
      check($sformatf("vec%0d_strobe", i + 1), sample_strobe, tbl[i].strobe);
    end
    mute = 1'b0;

    // Held 0xA5C3: both channels of the first frame decode to it.
    sample_in = 16'hA5C3;
    wait_words("a5c3_left", nl + 1, 1'b0);
    check("a5c3_left", last_left, 16'hA5C3);
    wait_words("a5c3_right", nr + 1, 1'b1);
    check("a5c3_right", last_right, 16'hA5C3);

    // Old right LSB survives the reload of the next sample.
    sample_in = 16'h8001;
    wait_strobe("s8001");
    sample_in = 16'h7FFE;
    wait_strobe("s7ffe");
    check("slot0_old_lsb", sdata, 1'b1);
    check("slot0_lrclk", lrclk, 1'b0);
    nl = n_left;
    nr = n_right;
    wait_words("r8001", nr + 1, 1'b1);
    check("right_8001", last_right, 16'h8001);
    wait_words("l7ffe", nl + 1, 1'b0);
    check("left_7ffe", last_left, 16'h7FFE);

    // Mute high only on the latch cycle.
    sample_in = 16'hFFFF;
    wait_strobe("pre_mute");
    repeat (FRAME_CLKS - 1) @(negedge clk);
    #1;
    mute = 1'b1;
    @(negedge clk); #1;
    check("mute_latch_strobe", sample_strobe, 1'b1);
    mute = 1'b0;
    nl = n_left;
    nr = n_right;
    wait_words("mute_l", nl + 1, 1'b0);
    check("mute_left", last_left, 16'h0000);
    wait_words("mute_r", nr + 2, 1'b1);
    check("mute_right", last_right, 16'h0000);
    wait_words("unmute_l", nl + 2, 1'b0);
    check("unmute_left", last_left, 16'hFFFF);
    wait_words("unmute_r", nr + 3, 1'b1);
    check("unmute_right", last_right, 16'hFFFF);

    // Random inputs every clock; only the values on latch cycles may reach the stream.
    nr = n_right;
    for (int i = 0; i < 6 * FRAME_CLKS; i++) begin
      sample_in = 16'($urandom);
      mute      = ($urandom_range(0, 7) == 0);
`ifdef VOLUME_SHIFT_EN
      volume_shift = 3'($urandom_range(0, 7));
`endif
      @(negedge clk); #1;
    end
    mute = 1'b0;
    check("random_words_seen", 32'((n_right - nr) >= 5), 32'd1);

`ifdef VOLUME_SHIFT_EN
    volume_shift = 3'd3;
    sample_in    = 16'h8000;
    wait_strobe("vol3");
    nl = n_left;
    wait_words("vol3_l", nl + 1, 1'b0);
    check("vol3_left", last_left, 16'hF000);
    volume_shift = 3'd7;
    sample_in    = 16'h4000;
    wait_strobe("vol7");
    nl = n_left;
    wait_words("vol7_l", nl + 1, 1'b0);
    check("vol7_left", last_left, 16'h0080);
    volume_shift = 3'd0;
`endif

    // Reset in slot 20, then the frame restarts 2*CLK_DIV clocks after release.
    sample_in = 16'h3C5A;
    wait_strobe("pre_reset");
    repeat (82) @(negedge clk);
    #1;
    check("slot20_lrclk", lrclk, 1'b1);
    reset = 1'b1;
    @(negedge clk); #1;
    check("midrst_bclk",   bclk,          1'b0);
    check("midrst_lrclk",  lrclk,         1'b0);
    check("midrst_sdata",  sdata,         1'b0);
    check("midrst_strobe", sample_strobe, 1'b0);
    reset = 1'b0;
    k = 0;
    for (int i = 1; i <= 8 * CLK_DIV; i++) begin
      @(negedge clk); #1;
      if (sample_strobe === 1'b1) begin
        k = i;
        break;
      end
    end
    check("restart_latency", k, 2 * CLK_DIV);
    nl = n_left;
    wait_words("restart_l", nl + 1, 1'b0);
    check("restart_left", last_left, 16'h3C5A);

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2s_sample_tx.md
Name: i2s_sample_tx

Overview:
Output stage directly downstream of the three-voice sample mixer. Latches the mixer's 16-bit two's-complement rendered sample once per audio frame. Serialises it as a stereo I2S stream to the DAC, with the same sample on left and right. Emits a one-clock frame strobe that upstream oscillator/envelope stages use to advance to the next sample.

Parameters:
CLK_DIV, 16, system clocks per BCLK half-period; legal range 1..255 (50 MHz / (2*16*32) = 48.8 kHz frame rate).
SAMPLE_W, 16, bits per channel; fixed at 16 for this design; frame is 2*SAMPLE_W = 32 BCLK periods.

Ports:
clk  in  1  system clock; all logic on rising edge.
reset  in  1  synchronous, active-high reset.
sample_in  in  16  mixer renderedSample, two's complement; only sampled at frame start.
mute  in  1  when high at frame start, the latched sample is forced to 0.
sample_strobe  out  1  one-clk pulse on the cycle sample_in is latched.
bclk  out  1  I2S bit clock.
lrclk  out  1  I2S word select; 0 = left, 1 = right.
sdata  out  1  I2S serial data, MSB first.

Behaviour:
- Reset values: bclk=0, lrclk=0, sdata=0, sample_strobe=0, latched sample=0, divider=0, slot counter=31, pending right-LSB bit=0.
- Divider: counts 0..CLK_DIV-1. On terminal count: wraps to 0 and bclk toggles. bclk period = 2*CLK_DIV clks, 50% duty.
- A "fall event" is the clk cycle on which bclk goes 1->0. All of lrclk, sdata and the slot counter update only on fall events. sdata/lrclk are stable across every bclk rising edge.
- Slot counter: increments mod 32 on each fall event. The first fall event after reset starts slot 0, which occurs 2*CLK_DIV clks after reset deasserts.
- lrclk: 0 during slots 0..15, 1 during slots 16..31.
- sdata per slot (standard I2S one-bit delay), with S = latched sample:
  - slot 0: bit 0 of the previous frame's right word (0 on the first frame after reset).
  - slots 1..16: S[16-k] for slot k.
  - slots 17..31: S[32-k] for slot k.
- Latch: on the fall event that starts slot 0, S <= mute ? 0 : sample_in. sample_strobe=1 on exactly that clk, otherwise 0.
  - S is held constant for the whole frame until its right LSB has been output in the next frame's slot 0.
  - The new value is latched on the same edge, so the old right LSB must be kept in a separate bit.
- Latency: sample_in captured at slot 0 start; its MSB appears on sdata at slot 1 start, 2*CLK_DIV clks later.
- sample_in changes outside the latch cycle have no effect. mute is sampled only on the latch cycle.
- No arithmetic on the sample: the mixer output is passed bit-exact, including wrapped overflow values.
- Reset mid-frame: all outputs return to reset values on the next clk edge. The partial frame is abandoned; the next frame restarts at slot 0 after 2*CLK_DIV clks.
- CLK_DIV=1: bclk toggles every clk; a fall event occurs every other clk.

Optional Feature:
Macro VOLUME_SHIFT_EN.
- Defined: adds input port volume_shift [2:0]. At latch, S <= mute ? 0 : (sample_in >>> volume_shift), an arithmetic shift with sign preserved. volume_shift is sampled on the latch cycle only. Example: 0x8000 with shift 3 gives 0xF000.
- Undefined: the port is absent and S = mute ? 0 : sample_in, as above.

Test Plan:
- Reset release, CLK_DIV=2: bclk first rises at clk 2 and falls at clk 4. sample_strobe pulses at clk 4. lrclk=0 and sdata=0 in slot 0.
- CLK_DIV=2, sample_in=0xA5C3 held: decode slots 1..16 -> 0xA5C3 with lrclk=0; slots 17..31 plus next slot 0 -> 0xA5C3 with lrclk=1. Frame length = 128 clks.
- sample_in 0x8001 in frame N, then 0x7FFE: next frame's slot 0 outputs 1 (old right LSB); slots 1..16 decode 0x7FFE.
- mute=1 only on the latch cycle with sample_in=0xFFFF: whole frame decodes 0x0000 on both channels; the following unmuted frame decodes 0xFFFF.
- reset asserted during slot 20: all outputs are 0 next clk. After release, strobe reappears exactly 2*CLK_DIV clks later.
- VOLUME_SHIFT_EN, sample_in=0x8000, volume_shift=3: decoded word = 0xF000. sample_in=0x4000, shift=7: decoded word = 0x0080.
